multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Moore-style main control FSM with ALU and immediate decoders that sequences a shared-memory multicycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal). It replaces the single-cycle combinational controller and lives inside the processor core, between the instruction register and the datapath muxes and enables. Each instruction is split into 3-5 states so one ALU and one memory serve fetch, address generation and execute.

Parameters:
TRAP_ON_ILLEGAL, 0, 0: an unknown opcode in DECODE returns to FETCH and pulses illegal. 1: it enters HALT, which is sticky until reset.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op  input  7  instruction opcode, from the instruction register
funct3  input  3  instruction funct3
funct7b5  input  1  instruction bit 30
zero  input  1  ALU zero flag, valid in the BEQ state
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = Result
MemWrite  output  1  data memory write enable
IRWrite  output  1  instruction register and OldPC enable
RegWrite  output  1  register file write enable
ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = A (rs1)
ALUSrcB  output  2  00 = WriteData (rs2), 01 = ImmExt, 10 = constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  output  2  00 I-type, 01 S-type, 10 B-type, 11 J-type
illegal  output  1  one-cycle pulse on an unknown opcode in DECODE
halted  output  1  high while in HALT
state  output  4  current state encoding, for debug

Behaviour:
- State register updates on the rising clk edge. reset=1 loads FETCH.
- While reset=1, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 and illegal is 0.
- Encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10, HALT=11. Encodings 12-15 go to FETCH on the next edge.
- All outputs are combinational from state (and from op/funct/zero where noted). Any field not listed for a state is 0 / 00.
- Internal signals: PCUpdate, Branch, ALUOp. PCWrite = PCUpdate | (Branch & zero).
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=1. Next: DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (computes the branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - any other op -> illegal=1 for this cycle, then FETCH (TRAP_ON_ILLEGAL=0) or HALT (TRAP_ON_ILLEGAL=1)
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next: MEMREAD if op=0000011, otherwise MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Next: MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. Next: FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next: FETCH.
- HALT: all enables 0, halted=1, stays in HALT until reset.
- Latency in cycles: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
- ALU decoder:
  - ALUOp 00 -> 000; ALUOp 01 -> 001.
  - ALUOp 10 by funct3: 000 -> 001 if (op[5] & funct7b5), else 000; 010 -> 101; 110 -> 011; 111 -> 010; any other funct3 -> 000.
  - ALUOp 11 -> 000.
- ImmSrc, decoded from op in every state: 0000011/0010011 -> 00, 0100011 -> 01, 1100011 -> 10, 1101111 -> 11, any other op -> 00.
- Reset in any state, including HALT or mid-MEMWRITE, takes effect on that edge. No partial write survives, because MemWrite is gated by reset in the same cycle.

Test Plan:
- lw (op=0000011) after reset release -> states 0,1,2,3,4,0. IRWrite=1 and PCWrite=1 only in FETCH. RegWrite=1 with ResultSrc=01 only in MEMWB.
- sw (op=0100011) -> states 0,1,2,5,0. MemWrite=1 with AdrSrc=1 in exactly one cycle. ImmSrc=01 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. addi (op=0010011, funct3=000, funct7b5=1) -> ALUControl=000 in EXECUTEI. Both then pass through ALUWB with RegWrite=1.
- beq with zero=1 -> PCWrite=1 in BEQ, 3-cycle instruction. Same instruction with zero=0 -> PCWrite=0 in BEQ. jal -> PCWrite=1 in JAL, then RegWrite=1 in ALUWB.
- op=0000000 with TRAP_ON_ILLEGAL=0 -> illegal high for one cycle in DECODE, state returns to 0. With TRAP_ON_ILLEGAL=1 -> state=11 and halted=1 for 20+ cycles. Asserting reset -> state=0, halted=0.
- reset asserted for one cycle while in MEMWRITE -> MemWrite=0 in that cycle, state=0 on the next edge. Fetch resumes when reset deasserts.

Source files
------------

// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle RV32I-subset datapath.
// It also contains the ALU and immediate decoders.
module multicycle_controller #(
  parameter bit TRAP_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic       halted,
  output logic [3:0] state
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    ALUWB    = 4'd7,
    EXECUTEI = 4'd8,
    JAL      = 4'd9,
    BEQ      = 4'd10,
    HALT     = 4'd11
  } stateT;

  stateT      currState;
  stateT      nextState;
  logic       pcUpdate;
  logic       branch;
  logic [1:0] aluOp;
  logic       irWriteRaw;
  logic       regWriteRaw;
  logic       memWriteRaw;
  logic       illegalRaw;

  always_ff @(posedge clk) begin
    if (reset) currState <= FETCH;
    else       currState <= nextState;
  end

  // Next state and per-state datapath controls
  always_comb begin
    nextState   = FETCH;
    pcUpdate    = 1'b0;
    branch      = 1'b0;
    aluOp       = 2'b00;
    irWriteRaw  = 1'b0;
    regWriteRaw = 1'b0;
    memWriteRaw = 1'b0;
    illegalRaw  = 1'b0;
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    halted      = 1'b0;
    case (currState)
      FETCH: begin
        irWriteRaw = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pcUpdate   = 1'b1;
        nextState  = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECUTER;
          OP_ITYPE:          nextState = EXECUTEI;
          OP_JAL:            nextState = JAL;
          OP_BEQ:            nextState = BEQ;
          default: begin
            illegalRaw = 1'b1;
            nextState  = TRAP_ON_ILLEGAL ? HALT : FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        nextState = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc    = 1'b1;
        nextState = MEMWB;
      end
      MEMWB: begin
        ResultSrc   = 2'b01;
        regWriteRaw = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc      = 1'b1;
        memWriteRaw = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA   = 2'b10;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA   = 2'b10;
        ALUSrcB   = 2'b01;
        aluOp     = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
      end
      JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pcUpdate  = 1'b1;
        nextState = ALUWB;
      end
      BEQ: begin
        ALUSrcA = 2'b10;
        aluOp   = 2'b01;
        branch  = 1'b1;
      end
      HALT: begin
        halted    = 1'b1;
        nextState = HALT;
      end
      default: nextState = FETCH;
    endcase
  end

  // ALU decoder
  always_comb begin
    ALUControl = 3'b000;
    case (aluOp)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Immediate format decoder, independent of state
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_STORE: ImmSrc = 2'b01;
      OP_BEQ:   ImmSrc = 2'b10;
      OP_JAL:   ImmSrc = 2'b11;
      default:  ImmSrc = 2'b00;
    endcase
  end

  // Reset masks every architectural write in the same cycle
  assign PCWrite  = ~reset & (pcUpdate | (branch & zero));
  assign IRWrite  = ~reset & irWriteRaw;
  assign RegWrite = ~reset & regWriteRaw;
  assign MemWrite = ~reset & memWriteRaw;
  assign illegal  = ~reset & illegalRaw;
  assign state    = currState;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller.
// An instruction-level reference model supplies the expected outputs for every cycle.
module tb_multicycle_controller;

  localparam int CL_LW = 0, CL_SW = 1, CL_R = 2, CL_I = 3, CL_JAL = 4, CL_BEQ = 5, CL_ILL = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, reset1;
  logic [6:0] op, op1;
  logic [2:0] funct3;
  logic       funct7b5, zero;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, halted;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  logic       PCWrite1, AdrSrc1, MemWrite1, IRWrite1, RegWrite1, illegal1, halted1;
  logic [1:0] ResultSrc1, ALUSrcA1, ALUSrcB1, ImmSrc1;
  logic [2:0] ALUControl1;
  logic [3:0] state1;

  int checks = 0;
  int errors = 0;

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b0)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal), .halted(halted), .state(state)
  );

  multicycle_controller #(.TRAP_ON_ILLEGAL(1'b1)) dutTrap (
    .clk(clk), .reset(reset1), .op(op1), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .PCWrite(PCWrite1), .AdrSrc(AdrSrc1), .MemWrite(MemWrite1), .IRWrite(IRWrite1),
    .RegWrite(RegWrite1), .ResultSrc(ResultSrc1), .ALUSrcA(ALUSrcA1), .ALUSrcB(ALUSrcB1),
    .ALUControl(ALUControl1), .ImmSrc(ImmSrc1), .illegal(illegal1), .halted(halted1), .state(state1)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic isLegal(input logic [6:0] o);
    return (o == 7'b0000011) || (o == 7'b0100011) || (o == 7'b0110011) ||
           (o == 7'b0010011) || (o == 7'b1101111) || (o == 7'b1100011);
  endfunction

  function automatic logic [6:0] opFor(input int cls);
    logic [6:0] o;
    case (cls)
      CL_LW:   o = 7'b0000011;
      CL_SW:   o = 7'b0100011;
      CL_R:    o = 7'b0110011;
      CL_I:    o = 7'b0010011;
      CL_JAL:  o = 7'b1101111;
      CL_BEQ:  o = 7'b1100011;
      default: begin
        o = 7'($urandom);
        while (isLegal(o)) o = 7'($urandom);
      end
    endcase
    return o;
  endfunction

  function automatic int latencyOf(input int cls);
    case (cls)
      CL_LW:   return 5;
      CL_BEQ:  return 3;
      CL_ILL:  return 2;
      default: return 4;
    endcase
  endfunction

  // State visited at cycle k of an instruction of the given class
  function automatic int stateAt(input int cls, input int k);
    int seq[7][5] = '{'{0, 1, 2, 3, 4}, '{0, 1, 2, 5, 0}, '{0, 1, 6, 7, 0}, '{0, 1, 8, 7, 0},
                      '{0, 1, 9, 7, 0}, '{0, 1, 10, 0, 0}, '{0, 1, 0, 0, 0}};
    return seq[cls][k];
  endfunction

  function automatic logic [2:0] expAluOp(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o[5] & f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] expImm(input logic [6:0] o);
    if (o == 7'b0100011) return 2'b01;
    if (o == 7'b1100011) return 2'b10;
    if (o == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  // Run the first n cycles of one instruction, starting at a negedge with the FSM in FETCH
  task automatic runInstr(input int cls, input logic [6:0] o, input logic [2:0] f3,
                          input logic f7, input int zv, input int n);
    logic expPc, expAdr, expMem, expIr, expReg, expIll, z;
    logic [1:0] expRes, expA, expB;
    logic [2:0] expAlu;
    for (int k = 0; k < n; k++) begin
      z = (zv < 0) ? 1'($urandom) : 1'(zv);
      op = o; funct3 = f3; funct7b5 = f7; zero = z;
      #1;
      {expPc, expAdr, expMem, expIr, expReg, expIll} = '0;
      expRes = 2'b00; expA = 2'b00; expB = 2'b00; expAlu = 3'b000;
      if (k == 0) begin
        expIr = 1'b1; expPc = 1'b1; expB = 2'b10; expRes = 2'b10;
      end else if (k == 1) begin
        expA = 2'b01; expB = 2'b01; expIll = (cls == CL_ILL);
      end else begin
        case (cls)
          CL_LW, CL_SW: begin
            if (k == 2) begin expA = 2'b10; expB = 2'b01; end
            else if (k == 3) begin expAdr = 1'b1; expMem = (cls == CL_SW); end
            else begin expRes = 2'b01; expReg = 1'b1; end
          end
          CL_R, CL_I: begin
            if (k == 2) begin
              expA = 2'b10; expB = (cls == CL_I) ? 2'b01 : 2'b00; expAlu = expAluOp(o, f3, f7);
            end else expReg = 1'b1;
          end
          CL_JAL: begin
            if (k == 2) begin expA = 2'b01; expB = 2'b10; expPc = 1'b1; end
            else expReg = 1'b1;
          end
          CL_BEQ: begin
            expA = 2'b10; expAlu = 3'b001; expPc = z;
          end
          default: ;
        endcase
      end
      checkVal($sformatf("state c%0d k%0d", cls, k), 32'(state), 32'(stateAt(cls, k)));
      checkVal($sformatf("ctl c%0d k%0d", cls, k),
               32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, illegal, halted}),
               32'({expPc, expAdr, expMem, expIr, expReg, expRes, expA, expB, expIll, 1'b0}));
      checkVal($sformatf("alu c%0d k%0d", cls, k), 32'(ALUControl), 32'(expAlu));
      checkVal($sformatf("imm c%0d k%0d", cls, k), 32'(ImmSrc), 32'(expImm(o)));
      @(negedge clk);
    end
  endtask

  initial begin
    int cls;
    reset = 1'b1; reset1 = 1'b1;
    op = 7'b0000011; op1 = 7'b0000000; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    checkVal("rst state", 32'(state), 32'd0);
    checkVal("rst enables", 32'({PCWrite, IRWrite, RegWrite, MemWrite, illegal}), 32'd0);
    reset = 1'b0;

    // Directed instructions
    runInstr(CL_LW, opFor(CL_LW), 3'b010, 1'b0, -1, 5);
    runInstr(CL_SW, opFor(CL_SW), 3'b010, 1'b0, -1, 4);
    runInstr(CL_R, opFor(CL_R), 3'b000, 1'b1, -1, 4);
    runInstr(CL_I, opFor(CL_I), 3'b000, 1'b1, -1, 4);
    runInstr(CL_BEQ, opFor(CL_BEQ), 3'b000, 1'b0, 1, 3);
    runInstr(CL_BEQ, opFor(CL_BEQ), 3'b000, 1'b0, 0, 3);
    runInstr(CL_JAL, opFor(CL_JAL), 3'b000, 1'b0, -1, 4);
    runInstr(CL_ILL, 7'b0000000, 3'b000, 1'b0, -1, 2);

    // Random instruction stream
    for (int i = 0; i < 200; i++) begin
      cls = int'($urandom_range(0, 6));
      runInstr(cls, opFor(cls), 3'($urandom), 1'($urandom), -1, latencyOf(cls));
    end

    // Reset landing on a MEMWRITE cycle
    runInstr(CL_SW, opFor(CL_SW), 3'b010, 1'b0, -1, 3);
    reset = 1'b1;
    #1;
    checkVal("mw rst state", 32'(state), 32'd5);
    checkVal("mw rst MemWrite", 32'(MemWrite), 32'd0);
    @(negedge clk); #1;
    checkVal("mw rst next state", 32'(state), 32'd0);
    reset = 1'b0;
    runInstr(CL_LW, opFor(CL_LW), 3'b010, 1'b0, -1, 5);

    // Trapping instance: illegal op halts until reset
    reset1 = 1'b0;
    #1;
    checkVal("trap fetch", 32'({state1, IRWrite1}), 32'({4'd0, 1'b1}));
    @(negedge clk); #1;
    checkVal("trap decode", 32'({state1, illegal1}), 32'({4'd1, 1'b1}));
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      zero = 1'($urandom);
      #1;
      checkVal($sformatf("halt %0d", i),
               32'({state1, halted1, illegal1, PCWrite1, IRWrite1, RegWrite1, MemWrite1}),
               32'({4'd11, 1'b1, 5'b00000}));
    end
    @(negedge clk);
    reset1 = 1'b1;
    @(negedge clk); #1;
    checkVal("halt rst", 32'({state1, halted1}), 32'({4'd0, 1'b0}));
    reset1 = 1'b0;
    op1 = 7'b0000011;
    @(negedge clk); #1;
    checkVal("halt resume", 32'({state1, halted1}), 32'({4'd1, 1'b0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
